rf_collect: RTL and testbench
=============================

RF_COLLECT -- requirements
Module: rf_collect

Interface
- REQ-001: Parameter WORDWIDTH, default 32, bits per word.
- REQ-002: Parameter OUT_NUM, default 5, words per channel.
- REQ-003: Parameter CHANNEL, default 6, channels per frame; N = CHANNEL*OUT_NUM words per frame (default 30).
- REQ-004: clk  input  1  single clock, all logic on rising edge.
- REQ-005: rstn  input  1  reset, asynchronous, active-low.
- REQ-006: clear  input  1  synchronous abort of the partial frame being filled.
- REQ-007: in_valid  input  1  in_data holds a word.
- REQ-008: in_data  input  WORDWIDTH  serial word stream, word 0 first.
- REQ-009: in_ready  output  1  block accepts in_data this cycle.
- REQ-010: count  output  $clog2(N)  index the next accepted word is written to.
- REQ-011: out_valid  output  1  out_data holds a complete frame.
- REQ-012: out_ready  input  1  consumer takes the frame.
- REQ-013: out_data  output  N*WORDWIDTH  packed frame register.

Function
- REQ-014: A word is accepted when in_valid && in_ready; it is written to slice [(count+1)*WORDWIDTH-1 -: WORDWIDTH] of the fill buffer.
- REQ-015: Each accept increments count; an accept at count == N-1 completes the frame, wraps count to 0, and is the only event that completes a frame.
- REQ-016: Two states: FILL (out_valid=0) and HOLD (out_valid=1); FILL->HOLD on frame completion, HOLD->FILL on out_valid && out_ready with no completion in the same cycle.
- REQ-017: out_valid rises on the cycle after the completing accept (1-cycle latency from last word to out_valid).
- REQ-018: In HOLD, out_data and out_valid are held stable until out_ready is sampled high.
- REQ-019: clear zeroes count and discards the partial frame; out_valid and out_data of a pending complete frame are unaffected.
- REQ-020: clear and an accept in the same cycle: clear wins, the word is dropped, count = 0 next cycle.
- REQ-021: in_ready is combinational from state, count and out_ready only, never from in_valid.

Reset
- REQ-022: While rstn = 0: count = 0, out_valid = 0, out_data = 0, fill buffer = 0, state = FILL.
- REQ-023: Reset mid-frame or mid-HOLD discards all data; the first accepted word after release goes to index 0.

Configuration
- REQ-024: Macro RF_COLLECT_DBUF_EN selects double buffering.
- REQ-025: Without RF_COLLECT_DBUF_EN: fill buffer and out_data are the same register; in_ready = !out_valid; no word is accepted in HOLD.
- REQ-026: With RF_COLLECT_DBUF_EN: separate fill buffer copied to out_data on completion; in_ready = 1 except when count == N-1 && out_valid && !out_ready; a completion coinciding with out_ready keeps out_valid = 1 with the new frame (back-to-back frames, no bubble).

Structure
- REQ-027: Shared package holds the FSM state enum (FILL, HOLD) and the frame-size helper constant N.
- REQ-028: Single module, no sub-modules.

Verification
- REQ-029: Reset, then 30 words 0x1..0x1E with out_ready = 1 -> out_valid = 1 one cycle after word 30; slice 0 = 0x1, slice 29 = 0x1E; count = 0.
- REQ-030: Frame complete, out_ready = 0 for 10 cycles -> out_data and out_valid stable; in_ready = 0 (no DBUF) or 0 only at count 29 (DBUF).
- REQ-031: clear after 12 words, then 30 words 0xA0..0xBD -> slice 0 = 0xA0, no stale data from the aborted frame appears in out_data.
- REQ-032: clear asserted together with an accepted word 0xFF at count 7 -> count = 0 next cycle, 0xFF not written.
- REQ-033: DBUF, continuous in_valid and out_ready for 3 frames -> 90 accepts in 90 cycles, out_valid continuously high after the first completion.
- REQ-034: rstn dropped at count 15 -> all outputs 0 asynchronously; the next 30 words form a correct frame.

Source files
------------

// File: rtl/rf_collect_pkg.sv
// Shared definitions for the rf_collect frame collector: FSM state encoding,
// default geometry and the frame-size helper.
package rf_collect_pkg;

  // FILL: gathering words, no frame offered. HOLD: a complete frame is offered.
  typedef enum logic [0:0] {
    StFill = 1'b0,
    StHold = 1'b1
  } state_e;

  localparam int unsigned DefWordWidth = 32;
  localparam int unsigned DefOutNum    = 5;
  localparam int unsigned DefChannel   = 6;

  // Words per frame for a given channel count and words-per-channel.
  function automatic int unsigned frame_words(input int unsigned channel,
                                              input int unsigned out_num);
    return channel * out_num;
  endfunction

  // Frame size for the default geometry.
  localparam int unsigned N = frame_words(DefChannel, DefOutNum);

endpackage

// File: rtl/rf_collect.sv
// rf_collect: serial-to-parallel frame collector. Words arrive one per accept
// (word 0 first, stored in the lowest slice) and are presented as one packed
// frame with a valid/ready handshake.
// Build option: define RF_COLLECT_DBUF_EN for a separate fill buffer, which lets
// the next frame be gathered while the previous one is still held.
module rf_collect
  import rf_collect_pkg::*;
#(
  parameter int unsigned WORDWIDTH = DefWordWidth,
  parameter int unsigned OUT_NUM   = DefOutNum,
  parameter int unsigned CHANNEL   = DefChannel,
  localparam int unsigned NWords   = frame_words(CHANNEL, OUT_NUM),
  localparam int unsigned CntW     = $clog2(NWords)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [WORDWIDTH-1:0]        in_data,
  output logic                        in_ready,
  output logic [CntW-1:0]             count,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NWords*WORDWIDTH-1:0] out_data
);

  localparam int unsigned FrameW = NWords * WORDWIDTH;
  localparam logic [CntW-1:0] LastIdx = CntW'(NWords - 1);

  state_e state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [FrameW-1:0] data_q, data_d;

  logic accept;
  logic last;
  logic complete;
  logic [FrameW-1:0] fill_base;
  logic [FrameW-1:0] merged;

`ifdef RF_COLLECT_DBUF_EN
  logic [FrameW-1:0] buf_q, buf_d;
  assign fill_base = buf_q;
`else
  // Single buffer: the frame is assembled directly in the output register.
  assign fill_base = data_q;
`endif

  assign accept   = in_valid & in_ready;
  assign last     = (count_q == LastIdx);
  // clear beats a simultaneous accept, so a cleared word can never complete a frame.
  assign complete = accept & ~clear & last;

  assign count    = count_q;
  assign out_data = data_q;

  // Fill buffer with the incoming word dropped into the slot at count_q.
  always_comb begin
    merged = fill_base;
    for (int i = 0; i < NWords; i++) begin
      if (count_q == CntW'(i)) begin
        merged[i*WORDWIDTH +: WORDWIDTH] = in_data;
      end
    end
  end

  // Write index: advances per accept, wraps after the last word, zeroed by clear.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (accept) begin
      count_d = last ? '0 : count_q + CntW'(1);
    end
  end

`ifdef RF_COLLECT_DBUF_EN
  // Double buffer: words land in buf; a completion publishes the merged frame.
  always_comb begin
    buf_d  = buf_q;
    data_d = data_q;
    if (clear) begin
      buf_d = '0;
    end else if (accept) begin
      buf_d = merged;
      if (last) begin
        data_d = merged;
        buf_d  = '0;
      end
    end
  end
`else
  // Single buffer: a held frame is never touched, since no accept happens in HOLD.
  always_comb begin
    data_d = data_q;
    if (clear) begin
      if (state_q == StFill) begin
        data_d = '0;
      end
    end else if (accept) begin
      data_d = merged;
    end
  end
`endif

  // FSM next state: completion enters/keeps HOLD, a handshake without completion leaves it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: begin
        if (complete) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!complete && out_ready) begin
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // FSM outputs: in_ready depends only on state, count and out_ready.
  always_comb begin
    out_valid = (state_q == StHold);
`ifdef RF_COLLECT_DBUF_EN
    // Stall only the final word while the previous frame is still unconsumed.
    in_ready  = !(last && (state_q == StHold) && !out_ready);
`else
    in_ready  = (state_q == StFill);
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: write index and frame storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

`ifdef RF_COLLECT_DBUF_EN
  // Separate fill buffer register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end
`endif

endmodule

// File: tb/tb_rf_collect.sv
// Self-checking bench for rf_collect (default geometry: 30 words of 32 bits).
// Expected frames are pushed to a scoreboard queue as words are driven and are
// popped by a monitor at every out_valid/out_ready handshake.
module tb_rf_collect;

  localparam int unsigned WW = 32;
  localparam int unsigned NW = 30;
  localparam int unsigned FW = NW * WW;

  logic          clk;
  logic          rstn;
  logic          clear;
  logic          in_valid;
  logic [WW-1:0] in_data;
  logic          in_ready;
  logic [4:0]    count;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model of the frame being filled.
  logic [FW-1:0] m_frame;
  int            m_count = 0;
  logic [FW-1:0] m_last;
  logic [FW-1:0] scb[$];

  rf_collect dut (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .count    (count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WW-1:0] word_of(input logic [FW-1:0] f, input int i);
    return f[i*WW +: WW];
  endfunction

  function automatic int first_diff(input logic [FW-1:0] a, input logic [FW-1:0] b);
    for (int i = 0; i < NW; i++) begin
      if (a[i*WW +: WW] !== b[i*WW +: WW]) return i;
    end
    return 0;
  endfunction

  // Scoreboard monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      checks = checks + 1;
      if (scb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL scb_frame: unexpected frame, word0=%h, none expected", word_of(out_data, 0));
      end else begin
        logic [FW-1:0] exp;
        int d;
        exp = scb.pop_front();
        if (out_data !== exp) begin
          errors = errors + 1;
          d = first_diff(out_data, exp);
          $display("FAIL scb_frame: word %0d got %h expected %h", d, word_of(out_data, d),
                   word_of(exp, d));
        end
      end
    end
  end

  // Drive one word and wait (bounded) until it is accepted; updates the model.
  task automatic send_word(input logic [WW-1:0] d);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_frame[m_count*WW +: WW] = d;
    if (m_count == NW - 1) begin
      scb.push_back(m_frame);
      m_last  = m_frame;
      m_frame = '0;
      m_count = 0;
    end else begin
      m_count++;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    m_frame = '0;
    #2;
    checks = checks + 4;
    if (count !== 5'd0) begin
      errors++; $display("FAIL reset_count: got %0d required 0", count);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_out_data: word0 got %h required 0", word_of(out_data, 0));
    end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill;
    out_ready = 1'b1;
    for (int i = 0; i < NW; i++) send_word(WW'(i + 1));
    checks = checks + 4;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL fill_out_valid: got %b required 1", out_valid);
    end
    if (word_of(out_data, 0) !== 32'h1) begin
      errors++; $display("FAIL fill_slice0: got %h required 1", word_of(out_data, 0));
    end
    if (word_of(out_data, 29) !== 32'h1E) begin
      errors++; $display("FAIL fill_slice29: got %h required 1e", word_of(out_data, 29));
    end
    if (count !== 5'd0) begin
      errors++; $display("FAIL fill_count: got %0d required 0", count);
    end
    @(posedge clk);
    #1;
    checks = checks + 1;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL fill_release: out_valid got %b required 0", out_valid);
    end
  endtask

  task automatic test_hold;
    logic [FW-1:0] held;
    out_ready = 1'b0;
    for (int i = 0; i < NW; i++) send_word(WW'(32'h100 + i));
    held = m_last;
    for (int c = 0; c < 10; c++) begin
`ifndef RF_COLLECT_DBUF_EN
      // A word offered during HOLD must be refused.
      in_valid = 1'b1;
      in_data  = 32'hDEAD;
`endif
      @(posedge clk);
      #1;
      checks = checks + 4;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL hold_valid: cycle %0d got %b required 1", c, out_valid);
      end
      if (out_data !== held) begin
        errors++; $display("FAIL hold_data: cycle %0d word0 got %h required %h", c,
                           word_of(out_data, 0), word_of(held, 0));
      end
`ifdef RF_COLLECT_DBUF_EN
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL hold_in_ready: cycle %0d got %b required 1", c, in_ready);
      end
`else
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_in_ready: cycle %0d got %b required 0", c, in_ready);
      end
`endif
      if (count !== 5'd0) begin
        errors++; $display("FAIL hold_count: cycle %0d got %0d required 0", c, count);
      end
    end
    in_valid = 1'b0;
`ifdef RF_COLLECT_DBUF_EN
    for (int i = 0; i < NW - 1; i++) send_word(WW'(32'h140 + i));
    checks = checks + 3;
    if (count !== 5'd29) begin
      errors++; $display("FAIL hold_dbuf_count: got %0d required 29", count);
    end
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_dbuf_stall: in_ready got %b required 0", in_ready);
    end
    if (out_data !== held) begin
      errors++; $display("FAIL hold_dbuf_data: word0 got %h required %h",
                         word_of(out_data, 0), word_of(held, 0));
    end
    out_ready = 1'b1;
    send_word(WW'(32'h140 + 29));
    checks = checks + 2;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_dbuf_b2b: out_valid got %b required 1", out_valid);
    end
    if (out_data !== m_last) begin
      errors++; $display("FAIL hold_dbuf_new: word0 got %h required %h",
                         word_of(out_data, 0), word_of(m_last, 0));
    end
`else
    out_ready = 1'b1;
`endif
    @(posedge clk);
    #1;
    checks = checks + 1;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: out_valid got %b required 0", out_valid);
    end
  endtask

  task automatic test_clear;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_word(WW'(32'h50 + i));
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_frame = '0;
    m_count = 0;
    checks = checks + 1;
    if (count !== 5'd0) begin
      errors++; $display("FAIL clear_count: got %0d required 0", count);
    end
    for (int i = 0; i < NW; i++) send_word(WW'(32'hA0 + i));
    checks = checks + 2;
    if (word_of(out_data, 0) !== 32'hA0) begin
      errors++; $display("FAIL clear_slice0: got %h required a0", word_of(out_data, 0));
    end
    if (word_of(out_data, 11) !== 32'hAB) begin
      errors++; $display("FAIL clear_slice11: got %h required ab", word_of(out_data, 11));
    end
    @(posedge clk);
    #1;
    // Clear coinciding with an accepted word at index 7.
    for (int i = 0; i < 7; i++) send_word(WW'(32'hE0 + i));
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hFF;
    @(negedge clk);
    checks = checks + 1;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL clear_acc_ready: got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    m_frame = '0;
    m_count = 0;
    checks = checks + 1;
    if (count !== 5'd0) begin
      errors++; $display("FAIL clear_acc_count: got %0d required 0", count);
    end
    for (int i = 0; i < NW; i++) send_word(WW'(32'hE0 + i));
    checks = checks + 1;
    if (word_of(out_data, 7) !== 32'hE7) begin
      errors++; $display("FAIL clear_acc_slice7: got %h required e7", word_of(out_data, 7));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int c0;
    int elapsed;
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3 * NW; i++) begin
      send_word(WW'(32'h300 + i));
`ifdef RF_COLLECT_DBUF_EN
      if (i >= NW - 1) begin
        checks = checks + 1;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_valid: after word %0d got %b required 1", i, out_valid);
        end
      end
`endif
    end
    elapsed = cyc - c0;
    checks = checks + 1;
`ifdef RF_COLLECT_DBUF_EN
    if (elapsed != 90) begin
      errors++; $display("FAIL b2b_cycles: got %0d required 90", elapsed);
    end
`else
    if (elapsed != 92) begin
      errors++; $display("FAIL b2b_cycles: got %0d required 92", elapsed);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    checks = checks + 1;
    if (scb.size() != 0) begin
      errors++; $display("FAIL rst_mid_pending: got %0d frames required 0", scb.size());
    end
    for (int i = 0; i < 15; i++) send_word(WW'(32'h77 + i));
    #3;
    rstn = 1'b0;
    #1;
    checks = checks + 3;
    if (count !== 5'd0) begin
      errors++; $display("FAIL rst_mid_count: got %0d required 0", count);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid: got %b required 0", out_valid);
    end
    if (out_data !== '0) begin
      errors++; $display("FAIL rst_mid_data: word0 got %h required 0", word_of(out_data, 0));
    end
    m_frame = '0;
    m_count = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NW; i++) send_word(WW'(32'h200 + i));
    checks = checks + 2;
    if (word_of(out_data, 0) !== 32'h200) begin
      errors++; $display("FAIL rst_mid_slice0: got %h required 200", word_of(out_data, 0));
    end
    if (word_of(out_data, 14) !== 32'h20E) begin
      errors++; $display("FAIL rst_mid_slice14: got %h required 20e", word_of(out_data, 14));
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    checks = checks + 1;
    if (scb.size() != 0) begin
      errors++; $display("FAIL scb_drain: %0d frames never delivered, required 0", scb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
